tile_residual_packer: RTL and testbench

Parametrised, streaming successor to the single-shot `igpu` residual compressor. It accepts one tile of NUM_PIXELS × NUM_CHANNELS pixels over a valid/ready handshake and computes a per-channel minimum and bits-required header. It then emits a variable number of LINE_W-bit lines, tagged with a 2-bit format flag, over a second valid/ready handshake. It sits between the pixel fetch front-end and the line writer; unlike `igpu`, it tolerates output backpressure and supports any legal tile/line geometry.

---
 rtl/tile_residual_packer_pkg.sv | 36 +++
 rtl/tile_residual_packer_channel_stats.sv | 35 +++
 rtl/tile_residual_packer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_tile_residual_packer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_residual_packer_pkg.sv
// Shared types for the tile residual packer: line format flags, FSM states, geometry helpers.
// No logic; latency and backpressure are not applicable.
package tile_residual_packer_pkg;

    typedef enum logic [1:0] {
        FLAG_CONST = 2'b00,
        FLAG_COMP  = 2'b01,
        FLAG_RAW   = 2'b10
    } flag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ANALYZE,
        ST_PACK,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    function automatic int calc_br_w(input int channel_w);
        return $clog2(channel_w + 1);
    endfunction

    function automatic int calc_hdr_w(input int num_channels, input int channel_w);
        return num_channels * (channel_w + calc_br_w(channel_w));
    endfunction

    function automatic int calc_raw_lines(input int num_pixels, input int num_channels,
                                          input int channel_w, input int line_w);
        return (num_pixels * num_channels * channel_w) / line_w;
    endfunction

    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_residual_packer_channel_stats.sv
// Min, max and bits-required of one channel across a tile; purely combinational.
// Zero latency; no handshake, so no backpressure.
module tile_residual_packer_channel_stats #(
    parameter int NUM_PIXELS = 32,
    parameter int CHANNEL_W  = 8,
    parameter int BR_W       = 4
) (
    input  logic [NUM_PIXELS*CHANNEL_W-1:0] samples_i,
    output logic [CHANNEL_W-1:0]            min_o,
    output logic [CHANNEL_W-1:0]            max_o,
    output logic [BR_W-1:0]                 br_o
);

    logic [CHANNEL_W-1:0] sample;
    logic [CHANNEL_W-1:0] range_v;

    always_comb begin
        min_o   = samples_i[CHANNEL_W-1:0];
        max_o   = samples_i[CHANNEL_W-1:0];
        sample  = '0;
        range_v = '0;
        br_o    = '0;
        for (int i = 1; i < NUM_PIXELS; i++) begin
            sample = samples_i[i*CHANNEL_W +: CHANNEL_W];
            if (sample < min_o) min_o = sample;
            if (sample > max_o) max_o = sample;
        end
        range_v = max_o - min_o;
        // Highest set bit of the range gives the residual width.
        for (int b = 0; b < CHANNEL_W; b++) begin
            if (range_v[b]) br_o = BR_W'(b + 1);
        end
    end

endmodule

// File: rtl/tile_residual_packer.sv
// Captures one tile, emits header + min-relative residuals (or raw samples) as LINE_W-bit lines.
// Latency: last beat T0+2+E (const tile T0+2); PACK stalls while the output line is held by out_ready=0.
module tile_residual_packer
    import tile_residual_packer_pkg::*;
#(
    parameter int NUM_PIXELS   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int CHANNEL_W    = 8,
    parameter int LINE_W       = 512
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_CHANNELS*NUM_PIXELS*CHANNEL_W-1:0] in_pixels,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LINE_W-1:0]                       out_line,
    output logic [1:0]                              out_flag,
    output logic                                    out_last
);

    localparam int BR_W      = calc_br_w(CHANNEL_W);
    localparam int HDR_W     = calc_hdr_w(NUM_CHANNELS, CHANNEL_W);
    localparam int RAW_LINES = calc_raw_lines(NUM_PIXELS, NUM_CHANNELS, CHANNEL_W, LINE_W);
    localparam int TILE_W    = NUM_CHANNELS * NUM_PIXELS * CHANNEL_W;
    localparam int FLD_W     = CHANNEL_W + BR_W;
    localparam int CH_W      = calc_idx_w(NUM_CHANNELS);
    localparam int PX_W      = calc_idx_w(NUM_PIXELS);
    localparam int SH_W      = $clog2(2 * LINE_W + 1);
    localparam int SUM_W     = BR_W + CH_W + 1;

    typedef struct packed {
        logic [CHANNEL_W-1:0] min;
        logic [BR_W-1:0]      br;
    } chan_hdr_t;

    if ((TILE_W % LINE_W) != 0 || HDR_W > LINE_W) begin : g_bad_geometry
        $fatal(1, "tile_residual_packer: tile must split into whole lines and header must fit one line");
    end

    state_t               state_q, state_d;
    flag_t                flag_q, flag_d;
    logic [TILE_W-1:0]    pix_q;
    logic [CHANNEL_W-1:0] min_q [NUM_CHANNELS];
    logic [BR_W-1:0]      br_q  [NUM_CHANNELS];
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [PX_W-1:0]      px_q, px_d;
    logic [SH_W-1:0]      ptr_q, ptr_d;
    logic [LINE_W-1:0]    acc_q, acc_d;
    logic [LINE_W-1:0]    out_line_q, out_line_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 load_stats;

    logic [CHANNEL_W-1:0] samp     [NUM_CHANNELS][NUM_PIXELS];
    logic [CHANNEL_W-1:0] stat_min [NUM_CHANNELS];
    logic [CHANNEL_W-1:0] stat_max [NUM_CHANNELS];
    logic [BR_W-1:0]      stat_br  [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
            assign samp[c][i] = pix_q[(c*NUM_PIXELS+i)*CHANNEL_W +: CHANNEL_W];
        end
        tile_residual_packer_channel_stats #(
            .NUM_PIXELS (NUM_PIXELS),
            .CHANNEL_W  (CHANNEL_W),
            .BR_W       (BR_W)
        ) u_stats (
            .samples_i (pix_q[c*NUM_PIXELS*CHANNEL_W +: NUM_PIXELS*CHANNEL_W]),
            .min_o     (stat_min[c]),
            .max_o     (stat_max[c]),
            .br_o      (stat_br[c])
        );
    end

    // Tile analysis: header image, format decision and first non-empty channel.
    chan_hdr_t         hdr_fld;
    logic [HDR_W-1:0]  hdr_vec;
    logic [LINE_W-1:0] hdr_line;
    logic [SUM_W-1:0]  sum_br;
    logic              all_const;
    logic [31:0]       total_bits, line_cnt;
    flag_t             an_flag;
    logic [CH_W-1:0]   first_ch;

    always_comb begin
        hdr_fld   = '0;
        hdr_vec   = '0;
        hdr_line  = '0;
        sum_br    = '0;
        all_const = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            hdr_fld.min = stat_min[c];
            hdr_fld.br  = stat_br[c];
            hdr_vec[HDR_W-1-c*FLD_W -: FLD_W] = hdr_fld;
            sum_br = sum_br + SUM_W'(stat_br[c]);
            if (stat_min[c] != stat_max[c]) all_const = 1'b0;
        end
        hdr_line[LINE_W-1 -: HDR_W] = hdr_vec;
        total_bits = 32'(HDR_W) + 32'(NUM_PIXELS) * 32'(sum_br);
        line_cnt   = (total_bits + 32'(LINE_W - 1)) / 32'(LINE_W);
        if (all_const)                       an_flag = FLAG_CONST;
        else if (line_cnt < 32'(RAW_LINES))  an_flag = FLAG_COMP;
        else                                 an_flag = FLAG_RAW;
        first_ch = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (an_flag == FLAG_RAW || stat_br[c] != '0) first_ch = CH_W'(c);
        end
    end

    // Element datapath: current element placed MSB-first at the bit pointer.
    logic [CHANNEL_W-1:0] cur_samp, cur_diff, cur_val;
    logic [BR_W-1:0]      cur_w;
    logic [SH_W-1:0]      fill, shamt;
    logic [2*LINE_W-1:0]  ext;
    logic                 line_full;
    logic                 nxt_found, last_elem;
    logic [CH_W-1:0]      nxt_ch;
    logic                 is_raw;

    always_comb begin
        is_raw   = (flag_q == FLAG_RAW);
        cur_samp = samp[ch_q][px_q];
        cur_diff = cur_samp - min_q[ch_q];
        cur_w    = is_raw ? BR_W'(CHANNEL_W) : br_q[ch_q];
        cur_val  = '0;
        for (int b = 0; b < CHANNEL_W; b++) begin
            if (BR_W'(b) < cur_w) cur_val[b] = is_raw ? cur_samp[b] : cur_diff[b];
        end
        fill      = ptr_q + SH_W'(cur_w);
        shamt     = SH_W'(2 * LINE_W) - fill;
        ext       = {acc_q, {LINE_W{1'b0}}}
                  | ({{(2*LINE_W-CHANNEL_W){1'b0}}, cur_val} << shamt);
        line_full = (fill >= SH_W'(LINE_W));
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (CH_W'(c) > ch_q && (is_raw || br_q[c] != '0)) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(c);
            end
        end
        last_elem = (px_q == PX_W'(NUM_PIXELS - 1)) && !nxt_found;
    end

    always_comb begin
        state_d     = state_q;
        flag_d      = flag_q;
        ch_d        = ch_q;
        px_d        = px_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        out_line_d  = out_line_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        load_stats  = 1'b0;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_ANALYZE;
            end
            ST_ANALYZE: begin
                load_stats = 1'b1;
                flag_d     = an_flag;
                if (an_flag == FLAG_CONST) begin
                    out_line_d  = hdr_line;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    state_d     = ST_DRAIN;
                end else begin
                    acc_d   = (an_flag == FLAG_RAW) ? '0 : hdr_line;
                    ptr_d   = (an_flag == FLAG_RAW) ? '0 : SH_W'(HDR_W);
                    ch_d    = first_ch;
                    px_d    = '0;
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                if (!(out_valid_q && !out_ready)) begin
                    if (line_full) begin
                        acc_d = ext[LINE_W-1:0];
                        ptr_d = fill - SH_W'(LINE_W);
                    end else begin
                        acc_d = ext[2*LINE_W-1:LINE_W];
                        ptr_d = fill;
                    end
                    if (line_full || last_elem) begin
                        out_line_d  = ext[2*LINE_W-1:LINE_W];
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                    end
                    if (last_elem) begin
                        // A straddling final element leaves a tail line still to send.
                        if (line_full && fill != SH_W'(LINE_W)) begin
                            state_d = ST_FLUSH;
                        end else begin
                            out_last_d = 1'b1;
                            state_d    = ST_DRAIN;
                        end
                    end else if (px_q == PX_W'(NUM_PIXELS - 1)) begin
                        px_d = '0;
                        ch_d = nxt_ch;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (!(out_valid_q && !out_ready)) begin
                    out_line_d  = acc_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flag_q      <= FLAG_CONST;
            pix_q       <= '0;
            ch_q        <= '0;
            px_q        <= '0;
            ptr_q       <= '0;
            acc_q       <= '0;
            out_line_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                min_q[c] <= '0;
                br_q[c]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            ch_q        <= ch_d;
            px_q        <= px_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            out_line_q  <= out_line_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (state_q == ST_IDLE && in_valid) pix_q <= in_pixels;
            if (load_stats) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    min_q[c] <= stat_min[c];
                    br_q[c]  <= stat_br[c];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_line  = out_line_q;
    assign out_flag  = flag_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_tile_residual_packer.sv
// Directed bench for tile_residual_packer: const, ramp, boundary, raw, backpressure and reset tiles.
// Outputs sampled on the falling edge; cycle numbers count from the tile handshake edge.
module tb_tile_residual_packer;

    localparam int NP = 32;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int LW = 512;
    localparam int TW = NP * NC * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_pixels = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] out_line;
    logic [1:0]    out_flag;
    logic          out_last;

    tile_residual_packer #(
        .NUM_PIXELS   (NP),
        .NUM_CHANNELS (NC),
        .CHANNEL_W    (CW),
        .LINE_W       (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixels (in_pixels),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_line  (out_line),
        .out_flag  (out_flag),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cur_cyc  = 0;
    int            cyc;
    int            beats;
    int            vcount;
    logic [TW-1:0] tile;
    logic [TW-1:0] exp_raw;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] got_line [2];
    logic          got_last [2];
    logic [1:0]    got_flag [2];

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int c, input int i, input logic [CW-1:0] v);
        tile[(c*NP+i)*CW +: CW] = v;
    endtask

    task automatic build_const();
        tile = '0;
        for (int i = 0; i < NP; i++) begin
            set_pix(0, i, 8'd10);
            set_pix(1, i, 8'd20);
            set_pix(2, i, 8'd30);
            set_pix(3, i, 8'd255);
        end
        exp_line = '0;
        exp_line[511:464] = {8'd10, 4'd0, 8'd20, 4'd0, 8'd30, 4'd0, 8'd255, 4'd0};
    endtask

    task automatic build_ramp();
        tile = '0;
        for (int i = 0; i < NP; i++) set_pix(0, i, 8'(i));
        exp_line = '0;
        exp_line[511:464] = {8'd0, 4'd5, 36'd0};
        for (int i = 0; i < NP; i++) exp_line[463-5*i -: 5] = 5'(i);
    endtask

    // Presents the tile, waits for the handshake edge, returns in cycle T0+1.
    task automatic send_tile(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        in_pixels = tile;
        in_valid  = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_in_ready_idle"}, LW'(in_ready), LW'(1));
        @(negedge clk);
        in_valid = 1'b0;
        cur_cyc  = 1;
        check({tag, "_in_ready_busy"}, LW'(in_ready), LW'(0));
    endtask

    task automatic wait_beat(input string tag, input int limit, output int at);
        logic got;
        got = 1'b0;
        at  = -1;
        for (int k = 0; k < limit && !got; k++) begin
            @(negedge clk);
            cur_cyc++;
            if (out_valid) begin
                got = 1'b1;
                at  = cur_cyc;
            end
        end
        if (!got) check({tag, "_timeout"}, LW'(0), LW'(1));
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", LW'(out_valid), LW'(0));
        check("rst_out_line", out_line, '0);
        check("rst_out_flag", LW'(out_flag), LW'(0));
        check("rst_out_last", LW'(out_last), LW'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", LW'(in_ready), LW'(1));

        // Constant tile: header-only line at T0+2
        build_const();
        send_tile("const");
        wait_beat("const", 10, cyc);
        check("const_cycle", LW'(cyc), LW'(2));
        check("const_flag", LW'(out_flag), LW'(2'b00));
        check("const_last", LW'(out_last), LW'(1));
        check("const_line", out_line, exp_line);
        @(negedge clk);
        check("const_done_valid", LW'(out_valid), LW'(0));
        check("const_done_ready", LW'(in_ready), LW'(1));

        // Ramp on r: one compressed line at T0+34
        build_ramp();
        send_tile("ramp");
        wait_beat("ramp", 60, cyc);
        check("ramp_cycle", LW'(cyc), LW'(34));
        check("ramp_flag", LW'(out_flag), LW'(2'b01));
        check("ramp_last", LW'(out_last), LW'(1));
        check("ramp_line", out_line, exp_line);

        // Sum of br = 14: 496 bits, still one compressed line
        tile = '0;
        set_pix(0, 1, 8'd255);
        set_pix(1, 1, 8'd63);
        exp_line = '0;
        exp_line[511:464] = {8'd0, 4'd8, 8'd0, 4'd6, 8'd0, 4'd0, 8'd0, 4'd0};
        exp_line[455:448] = 8'hFF;
        exp_line[201:196] = 6'h3F;
        send_tile("b14");
        wait_beat("b14", 100, cyc);
        check("b14_cycle", LW'(cyc), LW'(66));
        check("b14_flag", LW'(out_flag), LW'(2'b01));
        check("b14_last", LW'(out_last), LW'(1));
        check("b14_line", out_line, exp_line);
        check("b14_tail_zero", LW'(out_line[15:0]), LW'(0));

        // Sum of br = 15: 528 bits does not beat raw, two raw lines
        set_pix(1, 1, 8'd127);
        exp_line = '0;
        exp_line[503:496] = 8'hFF;
        exp_line[247:240] = 8'h7F;
        send_tile("b15");
        wait_beat("b15_l0", 100, cyc);
        check("b15_l0_cycle", LW'(cyc), LW'(66));
        check("b15_l0_flag", LW'(out_flag), LW'(2'b10));
        check("b15_l0_last", LW'(out_last), LW'(0));
        check("b15_l0_line", out_line, exp_line);
        wait_beat("b15_l1", 100, cyc);
        check("b15_l1_cycle", LW'(cyc), LW'(130));
        check("b15_l1_flag", LW'(out_flag), LW'(2'b10));
        check("b15_l1_last", LW'(out_last), LW'(1));
        check("b15_l1_line", out_line, '0);

        // Raw tile under toggling out_ready
        tile = '0;
        exp_raw = '0;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < NP; i++) begin
                set_pix(c, i, 8'(c*37 + i*11 + 3));
                exp_raw[TW-1-(c*NP+i)*CW -: CW] = 8'(c*37 + i*11 + 3);
            end
        end
        send_tile("raw");
        beats = 0;
        for (int k = 0; k < 400 && beats < 2; k++) begin
            @(negedge clk);
            out_ready = ~out_ready;
            if (out_valid && out_ready) begin
                got_line[beats] = out_line;
                got_last[beats] = out_last;
                got_flag[beats] = out_flag;
                beats++;
            end
        end
        out_ready = 1'b1;
        check("raw_beats", LW'(beats), LW'(2));
        check("raw_l0_line", got_line[0], exp_raw[TW-1:LW]);
        check("raw_l1_line", got_line[1], exp_raw[LW-1:0]);
        check("raw_l0_last", LW'(got_last[0]), LW'(0));
        check("raw_l1_last", LW'(got_last[1]), LW'(1));
        check("raw_l0_flag", LW'(got_flag[0]), LW'(2'b10));
        check("raw_l1_flag", LW'(got_flag[1]), LW'(2'b10));
        @(negedge clk);
        check("raw_done_valid", LW'(out_valid), LW'(0));
        check("raw_done_ready", LW'(in_ready), LW'(1));

        // Backpressure: ramp beat held for 10 cycles
        build_ramp();
        out_ready = 1'b0;
        send_tile("bp");
        wait_beat("bp", 60, cyc);
        check("bp_cycle", LW'(cyc), LW'(34));
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_line", out_line, exp_line);
            check("bp_hold_valid", LW'(out_valid), LW'(1));
            check("bp_hold_last", LW'(out_last), LW'(1));
            check("bp_hold_flag", LW'(out_flag), LW'(2'b01));
            check("bp_in_ready", LW'(in_ready), LW'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_valid", LW'(out_valid), LW'(0));
        check("bp_after_ready", LW'(in_ready), LW'(1));
        count_valid(5, vcount);
        check("bp_one_handshake", LW'(vcount), LW'(0));

        // Reset while a beat is being held
        build_ramp();
        out_ready = 1'b0;
        send_tile("rstv");
        wait_beat("rstv", 60, cyc);
        rst = 1'b1;
        #1;
        check("rstv_valid_drop", LW'(out_valid), LW'(0));
        check("rstv_line_clear", out_line, '0);
        check("rstv_last_clear", LW'(out_last), LW'(0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        count_valid(40, vcount);
        check("rstv_no_beats", LW'(vcount), LW'(0));

        // Reset at T0+10 of a ramp tile, then a constant tile
        build_ramp();
        send_tile("rst10");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst10_valid", LW'(out_valid), LW'(0));
        @(negedge clk);
        rst = 1'b0;
        count_valid(40, vcount);
        check("rst10_no_beats", LW'(vcount), LW'(0));
        check("rst10_in_ready", LW'(in_ready), LW'(1));
        build_const();
        send_tile("post");
        wait_beat("post", 10, cyc);
        check("post_cycle", LW'(cyc), LW'(2));
        check("post_flag", LW'(out_flag), LW'(2'b00));
        check("post_last", LW'(out_last), LW'(1));
        check("post_line", out_line, exp_line);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
